// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day core: set-mode encoding, field widths
// and the default wrap limits of each time field.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_DAY  = 2'd1,
        SET_HOUR = 2'd2,
        SET_MIN  = 2'd3
    } mode_t;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int DAY_W  = 3;

    localparam int SEC_MAX_DEF  = 59;
    localparam int MIN_MAX_DEF  = 59;
    localparam int HOUR_MAX_DEF = 23;
    localparam int DAY_MAX_DEF  = 6;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; wrap flags the increment
// that takes the value from MAX back to 0, so callers can chain carries.
module mod_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] value_reg;

    assign wrap  = inc && (value_reg == MAX_V);
    assign value = value_reg;

    // Clear beats increment: the caller relies on this when a tick and a
    // mode change land together, while wrap still reports the tick's carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_reg <= '0;
        end else if (clr) begin
            value_reg <= '0;
        end else if (inc) begin
            value_reg <= wrap ? '0 : value_reg + WIDTH'(1);
        end
    end

endmodule

// File: rtl/clock_keeper.sv
// Time-of-day core: seconds/minutes/hours/day-of-week carry chain driven by a
// 1 Hz tick, plus the mode/increment button set-mode state machine.
module clock_keeper
    import clock_pkg::*;
#(
    parameter int SEC_MAX  = SEC_MAX_DEF,
    parameter int MIN_MAX  = MIN_MAX_DEF,
    parameter int HOUR_MAX = HOUR_MAX_DEF,
    parameter int DAY_MAX  = DAY_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic              mode_btn,
    input  logic              inc_btn,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [DAY_W-1:0]  day,
    output logic [1:0]        mode,
    output logic              blink,
    output logic              day_rollover
);

    mode_t state_reg, state_next;
    logic  blink_reg, blink_next;
    logic  rollover_reg, rollover_next;

    logic  run;
    logic  set_inc;
    logic  sec_inc, sec_clr, sec_wrap;
    logic  min_inc, min_wrap;
    logic  hour_inc, hour_wrap;
    logic  day_inc;
    logic  unused_day_wrap;

    assign run     = (state_reg == RUN);
    // A mode press on the same cycle swallows the increment.
    assign set_inc = inc_btn && !mode_btn;

    assign sec_inc  = run && tick_1hz;
    assign sec_clr  = run && mode_btn;
    assign min_inc  = run ? sec_wrap  : (set_inc && state_reg == SET_MIN);
    assign hour_inc = run ? min_wrap  : (set_inc && state_reg == SET_HOUR);
    assign day_inc  = run ? hour_wrap : (set_inc && state_reg == SET_DAY);

    mod_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (sec_inc),
        .clr   (sec_clr),
        .value (sec),
        .wrap  (sec_wrap)
    );

    mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (min_inc),
        .clr   (1'b0),
        .value (min),
        .wrap  (min_wrap)
    );

    mod_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk   (clk),
        .reset (reset),
        .inc   (hour_inc),
        .clr   (1'b0),
        .value (hour),
        .wrap  (hour_wrap)
    );

    // The week wrap has no consumer; every carry-driven day step is reported.
    mod_counter #(.WIDTH(DAY_W), .MAX(DAY_MAX)) u_day (
        .clk   (clk),
        .reset (reset),
        .inc   (day_inc),
        .clr   (1'b0),
        .value (day),
        .wrap  (unused_day_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= RUN;
            blink_reg    <= 1'b0;
            rollover_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            blink_reg    <= blink_next;
            rollover_reg <= rollover_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        blink_next    = blink_reg;
        rollover_next = run && hour_wrap;

        if (mode_btn) begin
            blink_next = 1'b0;
            case (state_reg)
                RUN:      state_next = SET_DAY;
                SET_DAY:  state_next = SET_HOUR;
                SET_HOUR: state_next = SET_MIN;
                default:  state_next = RUN;
            endcase
        end else if (run) begin
            blink_next = 1'b0;
        end else if (tick_1hz) begin
            blink_next = ~blink_reg;
        end
    end

    assign mode         = state_reg;
    assign blink        = blink_reg;
    assign day_rollover = rollover_reg;

endmodule
